dmi_access_ctrl: RTL and testbench

DMI_ACCESS_CTRL -- requirements
Module: dmi_access_ctrl

---
 rtl/dmi_access_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_dmi_access_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_access_ctrl.sv
// dmi_access_ctrl: JTAG-side DMI access controller. Shifts the DMI data
// register, turns update strobes into debug-module requests, collects the
// responses and keeps a sticky error/busy status for the debugger.
module dmi_access_ctrl #(
  parameter  int unsigned AddrWidth = 7,
  localparam int unsigned DrWidth   = AddrWidth + 34
) (
  input  logic                 tck_i,
  input  logic                 trst_ni,
  input  logic                 dmi_access_i,
  input  logic                 capture_dr_i,
  input  logic                 shift_dr_i,
  input  logic                 update_dr_i,
  input  logic                 test_logic_reset_i,
  input  logic                 dmi_reset_i,
  input  logic                 tdi_i,
  output logic                 tdo_o,
  output logic [1:0]           dmi_error_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [AddrWidth-1:0] dmi_req_addr_o,
  output logic [31:0]          dmi_req_data_o,
  output logic [1:0]           dmi_req_op_o,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  input  logic [31:0]          dmi_resp_data_i,
  input  logic [1:0]           dmi_resp_i
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ       = 3'd1,
    ST_WAIT_READ  = 3'd2,
    ST_WRITE      = 3'd3,
    ST_WAIT_WRITE = 3'd4
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [DrWidth-1:0]   r_dr;
  logic [DrWidth-1:0]   w_dr_next;
  logic [AddrWidth-1:0] r_addr;
  logic [AddrWidth-1:0] w_addr_next;
  logic [31:0]          r_data;
  logic [31:0]          w_data_next;
  logic [1:0]           r_error;
  logic [1:0]           w_error_next;

  logic w_capture;
  logic w_shift;
  logic w_update;
  logic w_busy;
  logic w_busy_hit;

  // TAP strobes only count while DMIACCESS is the selected instruction.
  assign w_capture = dmi_access_i & capture_dr_i;
  assign w_shift   = dmi_access_i & shift_dr_i;
  assign w_update  = dmi_access_i & update_dr_i;
  assign w_busy    = (r_state != ST_IDLE);

  // A capture or an accepted update while a transaction is outstanding
  // means the debugger polled too early: flag busy.
  assign w_busy_hit = w_busy & (w_capture | (w_update & (r_error == 2'd0)));

  // Data register: capture a status snapshot, shift serially, clear on TLR.
  always_comb begin
    w_dr_next = r_dr;
    if (test_logic_reset_i) begin
      w_dr_next = {DrWidth{1'b0}};
    end else if (w_capture) begin
      if (w_busy) begin
        w_dr_next = {r_addr, r_data, 2'd3};
      end else begin
        w_dr_next = {r_addr, r_data, r_error};
      end
    end else if (w_shift) begin
      w_dr_next = {tdi_i, r_dr[DrWidth-1:1]};
    end else begin
      w_dr_next = r_dr;
    end
  end

  // Transaction FSM next state plus addr/data/error updates.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_data_next  = r_data;
    w_error_next = r_error;
    case (r_state)
      ST_IDLE: begin
        if (w_update && (r_error == 2'd0)) begin
          case (r_dr[1:0])
            2'd1: begin
              w_addr_next  = r_dr[DrWidth-1 -: AddrWidth];
              w_state_next = ST_READ;
            end
            2'd2: begin
              w_addr_next  = r_dr[DrWidth-1 -: AddrWidth];
              w_data_next  = r_dr[33:2];
              w_state_next = ST_WRITE;
            end
            default: w_state_next = ST_IDLE;
          endcase
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_READ: begin
        if (dmi_req_ready_i) begin
          w_state_next = ST_WAIT_READ;
        end else begin
          w_state_next = ST_READ;
        end
      end
      ST_WRITE: begin
        if (dmi_req_ready_i) begin
          w_state_next = ST_WAIT_WRITE;
        end else begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WAIT_READ: begin
        if (dmi_resp_valid_i) begin
          w_data_next  = dmi_resp_data_i;
          w_state_next = ST_IDLE;
          if ((dmi_resp_i != 2'd0) && (r_error == 2'd0)) begin
            w_error_next = 2'd2;
          end else begin
            w_error_next = r_error;
          end
        end else begin
          w_state_next = ST_WAIT_READ;
        end
      end
      ST_WAIT_WRITE: begin
        if (dmi_resp_valid_i) begin
          w_state_next = ST_IDLE;
          if ((dmi_resp_i != 2'd0) && (r_error == 2'd0)) begin
            w_error_next = 2'd2;
          end else begin
            w_error_next = r_error;
          end
        end else begin
          w_state_next = ST_WAIT_WRITE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Clears take priority over any error set in the same cycle; TLR also
    // wipes the address/data but leaves the FSM to finish its handshakes.
    if (test_logic_reset_i) begin
      w_error_next = 2'd0;
      w_addr_next  = {AddrWidth{1'b0}};
      w_data_next  = 32'd0;
    end else if (dmi_reset_i) begin
      w_error_next = 2'd0;
    end else if (w_busy_hit) begin
      w_error_next = 2'd3;
    end else begin
      w_error_next = w_error_next;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge tck_i) begin
    if (!trst_ni) begin
      r_state <= ST_IDLE;
      r_dr    <= {DrWidth{1'b0}};
      r_addr  <= {AddrWidth{1'b0}};
      r_data  <= 32'd0;
      r_error <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_dr    <= w_dr_next;
      r_addr  <= w_addr_next;
      r_data  <= w_data_next;
      r_error <= w_error_next;
    end
  end

  // Request op is only presented while a request is pending.
  always_comb begin
    dmi_req_op_o = 2'd0;
    case (r_state)
      ST_READ:  dmi_req_op_o = 2'd1;
      ST_WRITE: dmi_req_op_o = 2'd2;
      default:  dmi_req_op_o = 2'd0;
    endcase
  end

  assign tdo_o            = r_dr[0];
  assign dmi_error_o      = r_error;
  assign dmi_req_valid_o  = (r_state == ST_READ) || (r_state == ST_WRITE);
  assign dmi_resp_ready_o = (r_state == ST_WAIT_READ) || (r_state == ST_WAIT_WRITE);
  assign dmi_req_addr_o   = r_addr;
  assign dmi_req_data_o   = r_data;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Directed bench for dmi_access_ctrl with a transaction-level reference model.
module tb_dmi_access_ctrl;

  localparam int AW  = 7;
  localparam int DRW = AW + 34;

  logic            tck_i = 1'b0;
  logic            trst_ni;
  logic            dmi_access_i, capture_dr_i, shift_dr_i, update_dr_i;
  logic            test_logic_reset_i, dmi_reset_i, tdi_i;
  logic            tdo_o;
  logic [1:0]      dmi_error_o;
  logic            dmi_req_valid_o, dmi_req_ready_i;
  logic [AW-1:0]   dmi_req_addr_o;
  logic [31:0]     dmi_req_data_o;
  logic [1:0]      dmi_req_op_o;
  logic            dmi_resp_valid_i, dmi_resp_ready_o;
  logic [31:0]     dmi_resp_data_i;
  logic [1:0]      dmi_resp_i;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  dmi_access_ctrl #(.AddrWidth(AW)) dut (
    .tck_i(tck_i), .trst_ni(trst_ni), .dmi_access_i(dmi_access_i),
    .capture_dr_i(capture_dr_i), .shift_dr_i(shift_dr_i), .update_dr_i(update_dr_i),
    .test_logic_reset_i(test_logic_reset_i), .dmi_reset_i(dmi_reset_i),
    .tdi_i(tdi_i), .tdo_o(tdo_o), .dmi_error_o(dmi_error_o),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_data_o(dmi_req_data_o),
    .dmi_req_op_o(dmi_req_op_o), .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_data_i(dmi_resp_data_i),
    .dmi_resp_i(dmi_resp_i)
  );

  always #5 tck_i = ~tck_i;

  // Reference model: one outstanding transaction record plus status.
  logic [DRW-1:0] m_dr;
  logic [AW-1:0]  m_addr;
  logic [31:0]    m_data;
  logic [1:0]     m_err;
  logic           m_busy, m_issued, m_wr;

  always @(posedge tck_i) begin : model
    logic [DRW-1:0] o_dr;
    logic [AW-1:0]  o_addr;
    logic [31:0]    o_data;
    logic [1:0]     o_err;
    logic           o_busy, o_issued, fail, hit;
    if (!trst_ni) begin
      m_dr = '0; m_addr = '0; m_data = '0; m_err = 2'd0;
      m_busy = 1'b0; m_issued = 1'b0; m_wr = 1'b0;
    end else begin
      o_dr = m_dr; o_addr = m_addr; o_data = m_data; o_err = m_err;
      o_busy = m_busy; o_issued = m_issued;
      fail = 1'b0; hit = 1'b0;
      if (o_busy && o_issued && dmi_resp_valid_i) begin
        m_busy = 1'b0; m_issued = 1'b0;
        if (!m_wr) m_data = dmi_resp_data_i;
        if (dmi_resp_i != 2'd0 && o_err == 2'd0) fail = 1'b1;
      end else if (o_busy && !o_issued && dmi_req_ready_i) begin
        m_issued = 1'b1;
      end
      if (dmi_access_i) begin
        if (shift_dr_i) m_dr = {tdi_i, o_dr[DRW-1:1]};
        if (capture_dr_i) begin
          m_dr = o_busy ? {o_addr, o_data, 2'd3} : {o_addr, o_data, o_err};
          if (o_busy) hit = 1'b1;
        end
        if (update_dr_i && o_err == 2'd0) begin
          if (o_busy) hit = 1'b1;
          else if (o_dr[1:0] == 2'd1 || o_dr[1:0] == 2'd2) begin
            m_busy = 1'b1; m_issued = 1'b0; m_wr = (o_dr[1:0] == 2'd2);
            m_addr = o_dr[DRW-1:34];
            if (m_wr) m_data = o_dr[33:2];
          end
        end
      end
      m_err = o_err;
      if (fail) m_err = 2'd2;
      if (hit) m_err = 2'd3;
      if (dmi_reset_i) m_err = 2'd0;
      if (test_logic_reset_i) begin
        m_dr = '0; m_addr = '0; m_data = '0; m_err = 2'd0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge tck_i) begin
    if (chk_en) begin
      chk("tdo",   64'(tdo_o),            64'(m_dr[0]));
      chk("err",   64'(dmi_error_o),      64'(m_err));
      chk("valid", 64'(dmi_req_valid_o),  64'(m_busy && !m_issued));
      chk("rready",64'(dmi_resp_ready_o), 64'(m_busy && m_issued));
      chk("addr",  64'(dmi_req_addr_o),   64'(m_addr));
      chk("data",  64'(dmi_req_data_o),   64'(m_data));
      chk("op",    64'(dmi_req_op_o),     (m_busy && !m_issued) ? (m_wr ? 64'd2 : 64'd1) : 64'd0);
    end
  end

  task automatic tick();
    @(posedge tck_i);
    @(negedge tck_i);
  endtask

  // Full DR scan: capture, shift DRW bits (collecting tdo), update.
  task automatic scan(input logic [DRW-1:0] din, output logic [DRW-1:0] dout);
    dmi_access_i = 1'b1; capture_dr_i = 1'b1; tick(); capture_dr_i = 1'b0;
    for (int i = 0; i < DRW; i++) begin
      dout[i] = tdo_o; shift_dr_i = 1'b1; tdi_i = din[i]; tick();
    end
    shift_dr_i = 1'b0; update_dr_i = 1'b1; tick(); update_dr_i = 1'b0;
    dmi_access_i = 1'b0; tdi_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] r);
    dmi_resp_valid_i = 1'b1; dmi_resp_data_i = d; dmi_resp_i = r; tick();
    dmi_resp_valid_i = 1'b0; dmi_resp_data_i = 32'd0; dmi_resp_i = 2'd0;
  endtask

  task automatic handshake();
    dmi_req_ready_i = 1'b1; tick(); dmi_req_ready_i = 1'b0;
  endtask

  logic [DRW-1:0] dout;

  initial begin
    trst_ni = 1'b0; dmi_access_i = 1'b0; capture_dr_i = 1'b0; shift_dr_i = 1'b0;
    update_dr_i = 1'b0; test_logic_reset_i = 1'b0; dmi_reset_i = 1'b0; tdi_i = 1'b0;
    dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0; dmi_resp_data_i = 32'd0; dmi_resp_i = 2'd0;
    @(negedge tck_i); tick(); tick();
    chk_en = 1'b1;
    chk("rst_err", 64'(dmi_error_o), 64'd0);
    chk("rst_valid", 64'(dmi_req_valid_o), 64'd0);
    chk("rst_tdo", 64'(tdo_o), 64'd0);
    trst_ni = 1'b1; tick();

    // Read 0x10, response DEADBEEF, read back via capture.
    scan({7'h10, 32'h0, 2'd1}, dout);
    chk("rd_valid", 64'(dmi_req_valid_o), 64'd1);
    chk("rd_op", 64'(dmi_req_op_o), 64'd1);
    handshake();
    chk("rd_rready", 64'(dmi_resp_ready_o), 64'd1);
    respond(32'hDEADBEEF, 2'd0);
    scan({DRW{1'b0}}, dout);
    chk("rd_dr", 64'(dout), 64'({7'h10, 32'hDEADBEEF, 2'd0}));

    // Write 0x04 with ready held low three cycles.
    scan({7'h04, 32'h12345678, 2'd2}, dout);
    for (int i = 0; i < 3; i++) begin
      chk("wr_hold_valid", 64'(dmi_req_valid_o), 64'd1);
      chk("wr_hold_fields", 64'({dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}),
          64'({7'h04, 32'h12345678, 2'd2}));
      tick();
    end
    handshake();
    respond(32'h0, 2'd0);
    chk("wr_idle", 64'({dmi_req_valid_o, dmi_resp_ready_o}), 64'd0);

    // Capture while in WaitRead flags busy; the update is ignored.
    scan({7'h01, 32'h0, 2'd1}, dout);
    handshake();
    scan({7'h05, 32'h55, 2'd2}, dout);
    chk("busy_dr", 64'(dout), 64'({7'h01, 32'h12345678, 2'd3}));
    chk("busy_err", 64'(dmi_error_o), 64'd3);
    chk("busy_noreq", 64'(dmi_req_valid_o), 64'd0);
    respond(32'hCAFEF00D, 2'd0);
    dmi_reset_i = 1'b1; tick(); dmi_reset_i = 1'b0;
    chk("dmireset", 64'(dmi_error_o), 64'd0);

    // Failed response sets error 2; next read issues nothing.
    scan({7'h02, 32'h0, 2'd1}, dout);
    handshake();
    respond(32'h0BADBEEF, 2'd2);
    chk("fail_err", 64'(dmi_error_o), 64'd2);
    scan({7'h03, 32'h0, 2'd1}, dout);
    chk("fail_dr", 64'(dout), 64'({7'h02, 32'h0BADBEEF, 2'd2}));
    chk("fail_noreq", 64'(dmi_req_valid_o), 64'd0);
    dmi_reset_i = 1'b1; tick(); dmi_reset_i = 1'b0;

    // WaitWrite: clear beats busy set, then TLR clears but handshake completes.
    scan({7'h08, 32'hAAAA5555, 2'd2}, dout);
    handshake();
    dmi_access_i = 1'b1; capture_dr_i = 1'b1; dmi_reset_i = 1'b1; tick();
    dmi_reset_i = 1'b0;
    chk("clr_wins", 64'(dmi_error_o), 64'd0);
    tick(); capture_dr_i = 1'b0; dmi_access_i = 1'b0;
    chk("busy_again", 64'(dmi_error_o), 64'd3);
    test_logic_reset_i = 1'b1; tick(); test_logic_reset_i = 1'b0;
    chk("tlr_fields", 64'({dmi_error_o, dmi_req_addr_o, dmi_req_data_o}), 64'd0);
    chk("tlr_rready", 64'(dmi_resp_ready_o), 64'd1);
    respond(32'h0, 2'd0);
    chk("tlr_done", 64'(dmi_resp_ready_o), 64'd0);

    // Strobes without DMIACCESS do nothing.
    shift_dr_i = 1'b1; tdi_i = 1'b1; tick(); tick(); tick();
    shift_dr_i = 1'b0; update_dr_i = 1'b1; capture_dr_i = 1'b1; tick();
    update_dr_i = 1'b0; capture_dr_i = 1'b0; tdi_i = 1'b0;
    chk("noaccess_tdo", 64'(tdo_o), 64'd0);

    // Reset in the middle of a read request.
    scan({7'h11, 32'h0, 2'd1}, dout);
    chk("pre_rst_valid", 64'(dmi_req_valid_o), 64'd1);
    trst_ni = 1'b0; tick();
    chk("mid_rst_outs", 64'({tdo_o, dmi_error_o, dmi_req_valid_o, dmi_resp_ready_o,
                             dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}), 64'd0);
    trst_ni = 1'b1; tick(); tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
